// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, branch flush,
// operand forwarding selects and a saturating load-use stall counter.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              ValidD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic              PCSrcE,
  input  logic [4:0]        RdM,
  input  logic [4:0]        RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic              ValidE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  LoadUseCount
);

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_NONE = 2'b00;

  logic lw_stall;
  logic bubble;

  // Forward select for one Execute source; Memory stage has priority
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  // Hazard detection; a redirect outranks the load-use stall
  always_comb begin
    lw_stall = 1'b0;
    if (ValidE && (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != 5'd0) && ValidD &&
        ((RdE == Rs1D) || (RdE == Rs2D)))
      lw_stall = 1'b1;
    bubble    = lw_stall | PCSrcE;
    StallF    = lw_stall & ~PCSrcE;
    StallD    = lw_stall & ~PCSrcE;
    FlushD    = PCSrcE;
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Pipeline register: bubble loads an all-zero instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ValidE      <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else if (bubble) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ValidE      <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      ALUSrcE     <= ALUSrcD;
      BranchE     <= BranchD;
      JumpE       <= JumpD;
      ValidE      <= ValidD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
    end
  end

  // Load-use stall cycle counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      LoadUseCount <= '0;
    else if (StallD && (LoadUseCount != {CNT_W{1'b1}}))
      LoadUseCount <= LoadUseCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed corner sequences, a forwarding vector table
// and randomized traffic against an instruction-level reference model.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  typedef struct packed {
    logic [XLEN-1:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]      rs1, rs2, rd;
    logic            regwrite, memwrite, alusrc, branch, jump, valid;
    logic [1:0]      resultsrc;
    logic [2:0]      aluctrl;
  } instr_t;

  typedef struct {
    logic [4:0] rs1e, rs2e, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] expa, expb;
  } fwd_vec_t;

  logic clk, rst;
  instr_t d;
  logic pcsrc;
  logic [4:0] rdm, rdw;
  logic rwm, rww;

  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0] ALUControlE;
  logic StallF, StallD, FlushD;
  logic [CNT_W-1:0] LoadUseCount;

  instr_t m_e;
  int     m_cnt;
  int     nchk = 0;
  int     nfail = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc), .PCPlus4D(d.pcp4),
    .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .RegWriteD(d.regwrite), .MemWriteD(d.memwrite), .ALUSrcD(d.alusrc),
    .BranchD(d.branch), .JumpD(d.jump), .ValidD(d.valid),
    .ResultSrcD(d.resultsrc), .ALUControlD(d.aluctrl),
    .PCSrcE(pcsrc), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LoadUseCount(LoadUseCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t e_actual();
    return {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE, ResultSrcE, ALUControlE};
  endfunction

  // Reference: a valid load in E whose destination a valid D instruction reads
  function automatic logic model_load_use(input instr_t e, input instr_t dd);
    logic is_load;
    is_load = e.valid && e.regwrite && (e.resultsrc == 2'b01) && (e.rd != 5'd0);
    return is_load && dd.valid && (e.rd == dd.rs1 || e.rd == dd.rs2);
  endfunction

  // Reference: youngest older producer (M before W) that writes the source
  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    logic [4:0] dst [2];
    logic       we  [2];
    logic [1:0] code [2];
    dst = '{rdm, rdw};
    we = '{rwm, rww};
    code = '{2'b10, 2'b01};
    for (int s = 0; s < 2; s++)
      if (we[s] && dst[s] != 5'd0 && dst[s] == rs) return code[s];
    return 2'b00;
  endfunction

  // Check hazard outputs, clock once, advance the model and check E state
  task automatic tick();
    logic lu;
    #1;
    lu = model_load_use(m_e, d);
    chk("StallF", 256'(StallF), 256'(lu && !pcsrc));
    chk("StallD", 256'(StallD), 256'(lu && !pcsrc));
    chk("FlushD", 256'(FlushD), 256'(pcsrc));
    chk("ForwardAE", 256'(ForwardAE), 256'(model_fwd(m_e.rs1)));
    chk("ForwardBE", 256'(ForwardBE), 256'(model_fwd(m_e.rs2)));
    @(posedge clk);
    m_e = (lu || pcsrc) ? '0 : d;
    if (lu && !pcsrc && m_cnt < CMAX) m_cnt++;
    #1;
    chk("E_regs", 256'(e_actual()), 256'(m_e));
    chk("LoadUseCount", 256'(LoadUseCount), 256'(m_cnt));
    @(negedge clk);
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.rd1 = $urandom; r.rd2 = $urandom; r.imm = $urandom; r.pc = $urandom; r.pcp4 = $urandom;
    r.rs1 = 5'($urandom_range(0, 3));
    r.rs2 = 5'($urandom_range(0, 3));
    r.rd  = 5'($urandom_range(0, 3));
    r.regwrite = 1'($urandom_range(0, 1));
    r.memwrite = 1'($urandom_range(0, 1));
    r.alusrc = 1'($urandom_range(0, 1));
    r.branch = 1'($urandom_range(0, 1));
    r.jump = 1'($urandom_range(0, 1));
    r.valid = ($urandom_range(0, 7) != 0);
    r.resultsrc = 2'($urandom_range(0, 2));
    r.aluctrl = 3'($urandom_range(0, 7));
    return r;
  endfunction

  fwd_vec_t fv [10];

  initial begin
    fv[0] = '{5'd3,  5'd4,  5'd3,  5'd3,  1'b1, 1'b1, 2'b10, 2'b00};
    fv[1] = '{5'd3,  5'd3,  5'd3,  5'd3,  1'b0, 1'b1, 2'b01, 2'b01};
    fv[2] = '{5'd3,  5'd3,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
    fv[3] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
    fv[4] = '{5'd7,  5'd9,  5'd9,  5'd7,  1'b1, 1'b1, 2'b01, 2'b10};
    fv[5] = '{5'd7,  5'd9,  5'd9,  5'd7,  1'b0, 1'b0, 2'b00, 2'b00};
    fv[6] = '{5'd31, 5'd31, 5'd31, 5'd5,  1'b1, 1'b0, 2'b10, 2'b10};
    fv[7] = '{5'd5,  5'd6,  5'd6,  5'd5,  1'b1, 1'b1, 2'b01, 2'b10};
    fv[8] = '{5'd12, 5'd12, 5'd12, 5'd12, 1'b1, 1'b0, 2'b10, 2'b10};
    fv[9] = '{5'd12, 5'd13, 5'd1,  5'd13, 1'b0, 1'b1, 2'b00, 2'b01};

    rst = 1'b0; d = '0; pcsrc = 1'b0; rdm = '0; rdw = '0; rwm = 1'b0; rww = 1'b0;
    m_e = '0; m_cnt = 0;
    #3;
    chk("reset_E", 256'(e_actual()), 256'(0));
    chk("reset_cnt", 256'(LoadUseCount), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    // Pass-through
    d = '0; d.rd1 = 32'h6; d.rd = 5'd5; d.regwrite = 1'b1; d.valid = 1'b1;
    tick();
    chk("pass_RD1E", 256'(RD1E), 256'(32'h6));
    chk("pass_RdE", 256'(RdE), 256'(5));
    chk("pass_ValidE", 256'(ValidE), 256'(1));
    chk("pass_StallD", 256'(StallD), 256'(0));

    // Load-use on x19
    d = '0; d.rs1 = 5'd2; d.rd = 5'd19; d.resultsrc = 2'b01; d.regwrite = 1'b1; d.valid = 1'b1;
    tick();
    d = '0; d.rs1 = 5'd19; d.rd = 5'd20; d.regwrite = 1'b1; d.valid = 1'b1;
    #1;
    chk("lu_StallF", 256'(StallF), 256'(1));
    chk("lu_StallD", 256'(StallD), 256'(1));
    tick();
    chk("lu_bubble_ValidE", 256'(ValidE), 256'(0));
    chk("lu_cnt", 256'(LoadUseCount), 256'(1));
    tick();
    chk("lu_reload_ValidE", 256'(ValidE), 256'(1));
    chk("lu_reload_Rs1E", 256'(Rs1E), 256'(19));
    chk("lu_reload_RdE", 256'(RdE), 256'(20));

    // Branch redirect coincident with load-use
    d = '0; d.rd = 5'd19; d.resultsrc = 2'b01; d.regwrite = 1'b1; d.valid = 1'b1;
    tick();
    d = '0; d.rs2 = 5'd19; d.rd = 5'd7; d.regwrite = 1'b1; d.valid = 1'b1; pcsrc = 1'b1;
    #1;
    chk("br_FlushD", 256'(FlushD), 256'(1));
    chk("br_StallD", 256'(StallD), 256'(0));
    chk("br_StallF", 256'(StallF), 256'(0));
    tick();
    chk("br_bubble_ValidE", 256'(ValidE), 256'(0));
    chk("br_bubble_RegWriteE", 256'(RegWriteE), 256'(0));
    chk("br_cnt", 256'(LoadUseCount), 256'(1));
    pcsrc = 1'b0;

    // Saturation: self-dependent load keeps re-triggering the stall
    d = '0; d.rs1 = 5'd19; d.rd = 5'd19; d.resultsrc = 2'b01; d.regwrite = 1'b1; d.valid = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("sat_cnt", 256'(LoadUseCount), 256'(15));
    tick();
    chk("sat_stall_pending", 256'(StallD), 256'(1));

    // Asynchronous reset between edges during a stall
    #2;
    rst = 1'b0;
    #1;
    chk("arst_E", 256'(e_actual()), 256'(0));
    chk("arst_StallD", 256'(StallD), 256'(0));
    chk("arst_StallF", 256'(StallF), 256'(0));
    chk("arst_cnt", 256'(LoadUseCount), 256'(0));
    m_e = '0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_ValidE", 256'(ValidE), 256'(1));
    chk("post_rst_RdE", 256'(RdE), 256'(19));

    // Forwarding select vectors
    for (int i = 0; i < 10; i++) begin
      d = '0; d.rs1 = fv[i].rs1e; d.rs2 = fv[i].rs2e; pcsrc = 1'b0;
      tick();
      rdm = fv[i].rdm; rdw = fv[i].rdw; rwm = fv[i].rwm; rww = fv[i].rww;
      #1;
      chk($sformatf("fwdA_%0d", i), 256'(ForwardAE), 256'(fv[i].expa));
      chk($sformatf("fwdB_%0d", i), 256'(ForwardBE), 256'(fv[i].expb));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      d = rand_instr();
      pcsrc = ($urandom_range(0, 3) == 0);
      rdm = 5'($urandom_range(0, 3));
      rdw = 5'($urandom_range(0, 3));
      rwm = 1'($urandom_range(0, 1));
      rww = 1'($urandom_range(0, 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operands, immediate and PC fields.
REQ-002 Parameter: CNT_W, 16, width of the load-use stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 RD1D, RD2D  input  XLEN  register-file read data for the instruction in Decode.
REQ-006 ImmExtD, PCD, PCPlus4D  input  XLEN  extended immediate, PC, PC+4 of the Decode instruction.
REQ-007 Rs1D, Rs2D, RdD  input  5  source and destination register indices in Decode.
REQ-008 RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ValidD  input  1  Decode control bits; ValidD=1 marks a real instruction.
REQ-009 ResultSrcD  input  2  result select (00 ALU, 01 load, 10 PC+4); ALUControlD  input  3  ALU op.
REQ-010 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-011 RdM, RdW  input  5; RegWriteM, RegWriteW  input  1  destination info of Memory and Writeback stages.
REQ-012 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  XLEN  registered Decode fields.
REQ-013 Rs1E, Rs2E, RdE  output  5; RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ValidE  output  1; ResultSrcE  output  2; ALUControlE  output  3  registered controls.
REQ-014 StallF, StallD, FlushD  output  1  hazard controls to Fetch and IF/ID register (combinational).
REQ-015 ForwardAE, ForwardBE  output  2  operand forwarding selects (combinational).
REQ-016 LoadUseCount  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-017 Normal operation: every rising edge, all *E outputs SHALL load the matching *D inputs; latency exactly one cycle.
REQ-018 lwStall SHALL be 1 when ValidE, ResultSrcE==01, RegWriteE, RdE!=0, ValidD, and (RdE==Rs1D or RdE==Rs2D); else 0.
REQ-019 StallF = StallD = lwStall AND NOT PCSrcE.
REQ-020 FlushD = PCSrcE.
REQ-021 Bubble load: when lwStall=1 or PCSrcE=1, the next edge SHALL load RegWriteE, MemWriteE, BranchE, JumpE, ValidE=0, ResultSrcE=00, ALUControlE=000, RdE=Rs1E=Rs2E=0; data fields (RD1E..PCPlus4E) SHALL also load 0.
REQ-022 PCSrcE has priority over lwStall; both active -> single bubble, StallF=StallD=0.
REQ-023 ForwardAE = 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00.
REQ-024 ForwardBE follows REQ-023 with Rs2E; Memory stage wins when RdM==RdW.
REQ-025 Register x0 SHALL never trigger a stall or a forward.
REQ-026 LoadUseCount SHALL increment by 1 on each edge where StallD=1 and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-027 Writeback-to-Decode same-cycle hazards need no handling here (register file writes on falling edge).

Reset
REQ-028 rst=0 SHALL immediately, without a clock, drive every registered output and LoadUseCount to 0.
REQ-029 Reset mid-stall SHALL drop lwStall (ValidE=0), deasserting StallF/StallD in the same reset interval.
REQ-030 First rising edge after rst rises SHALL perform a normal load per REQ-017.

Verification
REQ-031 Pass-through: RD1D=0x0000_0006, RdD=5, RegWriteD=1, ValidD=1 -> next edge RD1E=0x6, RdE=5, ValidE=1, StallD=0.
REQ-032 Load-use: E holds load to x19 (ResultSrcE=01), D has Rs1D=19 -> StallF=StallD=1, next edge ValidE=0, LoadUseCount=1, following edge reloads D instr.
REQ-033 Branch flush with coincident load-use: PCSrcE=1 and lwStall conditions -> FlushD=1, StallD=0, next edge bubble in E, LoadUseCount unchanged.
REQ-034 Forward priority: Rs1E=3, RdM=3, RdW=3, RegWriteM=RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; RdM=RdW=0 -> 00.
REQ-035 Saturation: CNT_W=4, hold load-use stall 20 cycles -> LoadUseCount reaches 0xF and stays.
REQ-036 Async reset: assert rst=0 between clock edges during stall -> all E outputs 0, StallD=0, LoadUseCount=0 before next edge.
